board_state_ram: RTL
====================

# board_state_ram

Parametrised pixel-board store for the drawing pipeline: a W×H array of PIX_BITS-wide pixels with a host read/write port and an independent read-only scan port for the VGA output stage. It extends the 1-bit board store with configurable geometry and colour depth, out-of-range index protection, registered read-valid flags and a hardware clear sequencer that sweeps the whole board. The block sits between the draw/cursor logic (host port) and the display timing generator (scan port).

## Interface
- W, 160, board width in pixels (X range 0..W-1)
- H, 120, board height in pixels (Y range 0..H-1)
- PIX_BITS, 1, bits per pixel
- CLEAR_VAL, 0, pixel value written by the clear sweep (PIX_BITS wide)
- XW, 8, index width for X (must satisfy 2^XW ≥ W)
- YW, 8, index width for Y (must satisfy 2^YW ≥ H)
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- indexX  in  XW  host pixel X
- indexY  in  YW  host pixel Y
- data  in  PIX_BITS  host write data
- wr_en  in  1  host write strobe
- rd_en  in  1  host read strobe
- clear_req  in  1  single-cycle request to start a clear sweep
- out  out  PIX_BITS  host read data
- out_valid  out  1  out holds data for a read accepted the previous cycle
- busy  out  1  clear sweep in progress; host port rejected
- scan_x  in  XW  display pixel X
- scan_y  in  YW  display pixel Y
- scan_pixel  out  PIX_BITS  display read data

## Operation
- States: IDLE, CLEAR. Reset forces CLEAR with sweep counters (cx,cy)=(0,0); reset mid-sweep restarts from (0,0).
- CLEAR: each cycle writes CLEAR_VAL to (cx,cy); cx increments to W-1 then wraps to 0 with cy+1; after writing (W-1,H-1) go to IDLE. Sweep = W*H cycles exactly.
- IDLE: clear_req=1 → CLEAR from (0,0). clear_req during CLEAR ignored.
- Host write in IDLE: wr_en=1 and indexX<W and indexY<H → pixel ← data. Out-of-range writes dropped.
- Host read in IDLE: rd_en=1 → next cycle out = pixel (0 if out of range), out_valid=1. rd_en=0 → out_valid=0 next cycle, out holds last value.
- In CLEAR: wr_en and rd_en ignored; out_valid=0; out holds.
- Same-cycle clear_req and wr_en/rd_en in IDLE: clear wins; write dropped, read not acknowledged (out_valid=0).
- Same-cycle host read and write to same address: read returns old contents.
- Scan port always active, including CLEAR: scan_pixel = memory at (scan_x,scan_y) sampled this cycle; 0 if out of range. Scan reads never disturb host port.
- Linear address = y*W + x, computed at full width; no aliasing for any in-range pair.

## Timing
- Reset values (cycle after reset sampled high): out=0, out_valid=0, busy=1, scan_pixel=0.
- busy is registered: high the cycle after CLEAR is entered, low the cycle after the last sweep write; for clear_req at edge n, busy=1 from n+1 through n+W*H.
- Host read latency 1 cycle; write visible to a read issued the next cycle.
- Scan read latency 1 cycle; a pixel written at edge n is seen by scan address presented at edge n+1 or later.
- Memory: one write port (host or sweep, muxed by state), two read ports; no combinational path from inputs to outputs.

## Test plan
- Post-reset sweep (W=8,H=4,PIX_BITS=2,CLEAR_VAL=2): pulse reset → busy=1 for 32 cycles then 0; reading every pixel returns 2.
- Write/read: write (3,1)=1, (7,3)=3, next cycle read each → out=1 then 3 with out_valid=1, 1 cycle after each rd_en.
- Bounds: write (8,0)=3 and (0,4)=3 → no pixel changes; read (8,0) → out=0, out_valid=1.
- Read-before-write: (2,2)=1, then same-cycle wr (2,2)=3 and rd (2,2) → out=1; following read → 3.
- Clear priority/mid-sweep reset: clear_req with wr_en (0,0)=3 → write dropped, busy 32 cycles; reset at sweep cycle 10 → busy continues 32 more cycles from restart; rd_en during busy → out_valid=0.
- Scan port: during sweep and idle, scan_pixel at each (x,y) matches host-port contents one cycle later; scan (9,5) → 0.

Source files
------------

// File: rtl/board_state_ram_if.sv
// board_state_ram_if
// Bundles the host pixel port and the display scan port of board_state_ram.
//   master : the draw/cursor logic and display timing side (drives indices,
//            strobes and clear requests, receives pixel data and status)
//   slave  : the board store itself
// Signals:
//   indexX/indexY  host pixel coordinate
//   data           host write data
//   wr_en/rd_en    host write/read strobes
//   clear_req      one-cycle request to start a clear sweep
//   out/out_valid  host read data and its valid flag
//   busy           clear sweep in progress
//   scan_x/scan_y  display pixel coordinate
//   scan_pixel     display read data
interface board_state_ram_if #(
   parameter int XW       = 8,
   parameter int YW       = 8,
   parameter int PIX_BITS = 1
) ();
   logic [XW-1:0]       indexX;
   logic [YW-1:0]       indexY;
   logic [PIX_BITS-1:0] data;
   logic                wr_en;
   logic                rd_en;
   logic                clear_req;
   logic [PIX_BITS-1:0] out;
   logic                out_valid;
   logic                busy;
   logic [XW-1:0]       scan_x;
   logic [YW-1:0]       scan_y;
   logic [PIX_BITS-1:0] scan_pixel;

   modport master (
      output indexX, indexY, data, wr_en, rd_en, clear_req, scan_x, scan_y,
      input  out, out_valid, busy, scan_pixel
   );

   modport slave (
      input  indexX, indexY, data, wr_en, rd_en, clear_req, scan_x, scan_y,
      output out, out_valid, busy, scan_pixel
   );
endinterface

// File: rtl/board_state_ram.sv
// board_state_ram
// W x H pixel board, PIX_BITS per pixel, with a host read/write port, an
// independent read-only scan port for the display, and a clear sequencer
// that writes CLEAR_VAL to every pixel (W*H cycles) after reset or on
// clear_req. While clearing the host port is ignored and busy is high.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; restarts the clear sweep from (0,0)
//   bus    board_state_ram_if.slave (host port, scan port, status)
module board_state_ram #(
   parameter int                  W         = 160,
   parameter int                  H         = 120,
   parameter int                  PIX_BITS  = 1,
   parameter logic [PIX_BITS-1:0] CLEAR_VAL = '0,
   parameter int                  XW        = 8,
   parameter int                  YW        = 8
) (
   input  logic               clk,
   input  logic               reset,
   board_state_ram_if.slave   bus
);
   localparam int DEPTH = W * H;
   localparam int AW    = $clog2(DEPTH);
   // y*W + x never exceeds 2^(XW+YW), so one extra bit is always enough.
   localparam int LW    = XW + YW + 1;
   localparam logic [XW:0] W_LIM = (XW+1)'(W);
   localparam logic [YW:0] H_LIM = (YW+1)'(H);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_reg;
   logic [XW-1:0]       cx_reg;
   logic [YW-1:0]       cy_reg;
   logic                busy_reg;
   logic [PIX_BITS-1:0] out_reg;
   logic                out_valid_reg;
   logic [PIX_BITS-1:0] scan_pixel_reg;

   logic [PIX_BITS-1:0] mem [DEPTH];

   function automatic logic [LW-1:0] lin_addr(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
      return LW'(y) * LW'(W) + LW'(x);
   endfunction

   logic [LW-1:0] host_lin, scan_lin, sweep_lin;
   logic          host_in_range, scan_in_range;
   logic          host_wr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [PIX_BITS-1:0] mem_wdata;
   logic          unused_hi;

   assign host_lin  = lin_addr(bus.indexX, bus.indexY);
   assign scan_lin  = lin_addr(bus.scan_x, bus.scan_y);
   assign sweep_lin = lin_addr(cx_reg, cy_reg);
   // Upper address bits only matter for out-of-range indices, which are
   // rejected by the explicit range checks below.
   assign unused_hi = ^{host_lin[LW-1:AW], scan_lin[LW-1:AW], sweep_lin[LW-1:AW]};

   assign host_in_range = ({1'b0, bus.indexX} < W_LIM) && ({1'b0, bus.indexY} < H_LIM);
   assign scan_in_range = ({1'b0, bus.scan_x} < W_LIM) && ({1'b0, bus.scan_y} < H_LIM);

   // clear_req outranks a same-cycle host write.
   assign host_wr   = (state_reg == IDLE) && !bus.clear_req && bus.wr_en && host_in_range;
   assign mem_we    = !reset && ((state_reg == CLEAR) || host_wr);
   assign mem_waddr = (state_reg == CLEAR) ? sweep_lin[AW-1:0] : host_lin[AW-1:0];
   assign mem_wdata = (state_reg == CLEAR) ? CLEAR_VAL : bus.data;

   // Single write port shared by host and sweep.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Sequencer plus host read port. Reads see pre-write contents because
   // the memory update above is non-blocking on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= CLEAR;
         cx_reg        <= '0;
         cy_reg        <= '0;
         busy_reg      <= 1'b1;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         case (state_reg)
            CLEAR: begin
               if (cx_reg == XW'(W - 1)) begin
                  cx_reg <= '0;
                  if (cy_reg == YW'(H - 1)) begin
                     cy_reg    <= '0;
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     cy_reg <= cy_reg + 1'b1;
                  end
               end else begin
                  cx_reg <= cx_reg + 1'b1;
               end
            end
            IDLE: begin
               if (bus.clear_req) begin
                  state_reg <= CLEAR;
                  busy_reg  <= 1'b1;
                  cx_reg    <= '0;
                  cy_reg    <= '0;
               end else if (bus.rd_en) begin
                  out_valid_reg <= 1'b1;
                  out_reg       <= host_in_range ? mem[host_lin[AW-1:0]] : '0;
               end
            end
         endcase
      end
   end

   // Scan port: always live, independent of the sequencer state.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_pixel_reg <= '0;
      end else begin
         scan_pixel_reg <= scan_in_range ? mem[scan_lin[AW-1:0]] : '0;
      end
   end

   assign bus.out        = out_reg;
   assign bus.out_valid  = out_valid_reg;
   assign bus.busy       = busy_reg;
   assign bus.scan_pixel = scan_pixel_reg;
endmodule
